// File: rtl/gat_pkg.sv
// Shared widths, FSM state encoding and word types for the sparse-row MAC datapath.
package gat_pkg;
   localparam int DATA_WIDTH    = 8;
   localparam int NUM_OF_COLS   = 5;
   localparam int COL_IDX_WIDTH = $clog2(NUM_OF_COLS);
   localparam int ROW_LEN_WIDTH = $clog2(NUM_OF_COLS);
   localparam int ACC_WIDTH     = 2*DATA_WIDTH + $clog2(NUM_OF_COLS);

   typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

   typedef logic signed [DATA_WIDTH-1:0]    value_t;
   typedef logic        [COL_IDX_WIDTH-1:0] col_idx_t;
   typedef logic signed [ACC_WIDTH-1:0]     acc_t;
endpackage

// File: rtl/spmv_row_mac_mac_unit.sv
// Signed multiply-accumulate: clr_i zeroes the accumulator, en_i adds a_i*b_i.
// acc_nxt_o exposes the sum including the current product so the caller can latch it.
module mac_unit
   import gat_pkg::*;
(
   input  logic   clk,
   input  logic   rst_n,
   input  logic   clr_i,
   input  logic   en_i,
   input  value_t a_i,
   input  value_t b_i,
   output acc_t   acc_nxt_o
);
   logic signed [2*DATA_WIDTH-1:0] prod;
   acc_t                           acc_q;

   assign prod      = a_i * b_i;
   assign acc_nxt_o = acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};

   always_ff @(posedge clk) begin
      if (!rst_n)     acc_q <= '0;
      else if (clr_i) acc_q <= '0;
      else if (en_i)  acc_q <= acc_nxt_o;
   end
endmodule

// File: rtl/spmv_row_mac.sv
// Dot product of one CSR row with a dense weight vector, one nonzero per cycle; result
// valid len_eff+1 cycles after accept, held until res_ready_i. SPMV_RELU_EN clamps negatives to 0.
module spmv_row_mac
   import gat_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 row_valid_i,
   output logic                                 row_ready_o,
   input  logic [COL_IDX_WIDTH*NUM_OF_COLS-1:0] row_col_idx_i,
   input  logic [DATA_WIDTH*NUM_OF_COLS-1:0]    row_value_i,
   input  logic [ROW_LEN_WIDTH-1:0]             row_len_i,
   input  logic                                 row_flag_i,
   input  logic [DATA_WIDTH*NUM_OF_COLS-1:0]    weight_i,
   output logic                                 res_valid_o,
   input  logic                                 res_ready_i,
   output logic [ACC_WIDTH-1:0]                 res_data_o,
   output logic                                 res_flag_o,
   output logic                                 busy_o
);
   state_e                   state_q, state_d;
   logic [ROW_LEN_WIDTH-1:0] k_q, k_d;
   logic [ROW_LEN_WIDTH-1:0] len_q, len_in;
   acc_t                     res_q, res_d;
   logic                     flag_q, flag_d;
   logic                     cap, clr, en;

   value_t   val_q [NUM_OF_COLS];
   value_t   wgt_q [NUM_OF_COLS];
   col_idx_t col_q [NUM_OF_COLS];

   value_t   op_a, op_b;
   col_idx_t cur_col;
   acc_t     acc_nxt, acc_fin;

   assign len_in = (row_len_i > ROW_LEN_WIDTH'(NUM_OF_COLS)) ? ROW_LEN_WIDTH'(NUM_OF_COLS) : row_len_i;

   // Element 0 lives in the most significant slice of each flat input bus.
   always_ff @(posedge clk) begin
      if (cap) begin
         len_q <= len_in;
         for (int i = 0; i < NUM_OF_COLS; i++) begin
            val_q[i] <= row_value_i[(NUM_OF_COLS-1-i)*DATA_WIDTH +: DATA_WIDTH];
            wgt_q[i] <= weight_i[(NUM_OF_COLS-1-i)*DATA_WIDTH +: DATA_WIDTH];
            col_q[i] <= row_col_idx_i[(NUM_OF_COLS-1-i)*COL_IDX_WIDTH +: COL_IDX_WIDTH];
         end
      end
   end

   assign cur_col = col_q[k_q];
   assign op_a    = val_q[k_q];
   assign op_b    = (cur_col < COL_IDX_WIDTH'(NUM_OF_COLS)) ? wgt_q[cur_col] : '0;

   mac_unit u_mac (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_i     (clr),
      .en_i      (en),
      .a_i       (op_a),
      .b_i       (op_b),
      .acc_nxt_o (acc_nxt)
   );

`ifdef SPMV_RELU_EN
   assign acc_fin = acc_nxt[ACC_WIDTH-1] ? '0 : acc_nxt;
`else
   assign acc_fin = acc_nxt;
`endif

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      res_d   = res_q;
      flag_d  = flag_q;
      cap     = 1'b0;
      clr     = 1'b0;
      en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (row_valid_i) begin
               cap     = 1'b1;
               clr     = 1'b1;
               k_d     = '0;
               flag_d  = row_flag_i;
               if (len_in == '0) begin
                  res_d   = '0;
                  state_d = DONE;
               end else begin
                  state_d = MAC;
               end
            end
         end
         MAC: begin
            en  = 1'b1;
            k_d = k_q + ROW_LEN_WIDTH'(1);
            if (k_q == len_q - ROW_LEN_WIDTH'(1)) begin
               res_d   = acc_fin;
               state_d = DONE;
            end
         end
         DONE: begin
            if (res_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         res_q   <= '0;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
      end
   end

   assign row_ready_o = (state_q == IDLE);
   assign res_valid_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign res_data_o  = res_q;
   assign res_flag_o  = flag_q;
endmodule
